handshake_sync_rx: RTL and testbench

HANDSHAKE_SYNC_RX -- requirements
Module: handshake_sync_rx

---
 rtl/handshake_sync_rx_pkg.sv | 17 +
 rtl/handshake_sync_rx_if.sv | 24 ++
 rtl/handshake_sync_rx_sync_chain.sv | 25 ++
 rtl/handshake_sync_rx.sv | 95 +++++++++
 tb/tb_handshake_sync_rx.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/handshake_sync_rx_pkg.sv
// Shared definitions for the toggle-handshake receiver: FSM encoding and
// the legal synchronizer depth range.
package handshake_sync_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } rx_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  function automatic bit sync_depth_ok(input int depth);
    return (depth >= SYNC_STAGES_MIN) && (depth <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/handshake_sync_rx_if.sv
// Bundle of request/accept/status signals between the local consumer side
// and the handshake receiver.
interface handshake_sync_rx_if #(
  parameter int CNT_W = 8
);
  logic             req_toggle;
  logic             ready_in;
  logic             clr_overrun;
  logic             pulse_out;
  logic             busy;
  logic             ack_toggle;
  logic [CNT_W-1:0] event_cnt;
  logic             overrun;

  modport master (
    output req_toggle, ready_in, clr_overrun,
    input  pulse_out, busy, ack_toggle, event_cnt, overrun
  );

  modport slave (
    input  req_toggle, ready_in, clr_overrun,
    output pulse_out, busy, ack_toggle, event_cnt, overrun
  );
endinterface

// File: rtl/handshake_sync_rx_sync_chain.sv
// Multi-flop level synchronizer with async active-low reset; also usable on
// the transmit side to bring ack_toggle back.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  assign sync_d = {sync_q[STAGES-2:0], d_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/handshake_sync_rx.sv
// Receive side of a toggle handshake: synchronizes req_toggle, emits one
// strobe per request, tracks pending/accept, counts accepts, flags drops.
module handshake_sync_rx
  import handshake_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input logic                clk_slow,
  input logic                rst_n,
  handshake_sync_rx_if.slave bus
);

  if (!sync_depth_ok(SYNC_STAGES)) begin : g_bad_depth
    $error("handshake_sync_rx: SYNC_STAGES out of range");
  end

  logic             req_sync;
  logic             prev_q;
  logic             event_w;
  rx_state_e        state_q;
  logic             pulse_q;
  logic             busy_q;
  logic             ack_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ovr_q;
  logic             ovr_set_w;
  logic             ovr_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk_slow),
    .rst_n (rst_n),
    .d_i   (bus.req_toggle),
    .q_o   (req_sync)
  );

  assign event_w = req_sync ^ prev_q;
  assign cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // A request arriving while one is still outstanding and not being accepted
  // this cycle is lost; setting beats a simultaneous clear.
  assign ovr_set_w = (state_q == ST_PENDING) && event_w && !bus.ready_in;
  assign ovr_d     = ovr_set_w ? 1'b1 : (bus.clr_overrun ? 1'b0 : ovr_q);

  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      state_q <= ST_IDLE;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      prev_q  <= req_sync;
      pulse_q <= 1'b0;
      ovr_q   <= ovr_d;
      case (state_q)
        ST_IDLE: begin
          if (event_w) begin
            state_q <= ST_PENDING;
            busy_q  <= 1'b1;
            pulse_q <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (bus.ready_in) begin
            ack_q <= ~ack_q;
            cnt_q <= cnt_d;
            if (event_w) begin
              pulse_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pulse_out  = pulse_q;
  assign bus.busy       = busy_q;
  assign bus.ack_toggle = ack_q;
  assign bus.event_cnt  = cnt_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_handshake_sync_rx.sv
// Scoreboard bench: two receivers (depth 2 / 8-bit count, depth 4 / 3-bit
// count) share stimulus; a request-level model predicts every cycle.
module tb_handshake_sync_rx;

  localparam int S_A = 2;
  localparam int W_A = 8;
  localparam int S_B = 4;
  localparam int W_B = 3;

  typedef struct {
    bit pulse;
    bit busy;
    bit ack;
    bit ovr;
    int cnt;
  } exp_t;

  logic clk_slow = 1'b0;
  logic rst_n;
  logic req_toggle;
  logic ready_in;
  logic clr_overrun;

  int tests = 0;
  int fails = 0;
  bit verbose = 1'b1;

  exp_t q_a[$];
  exp_t q_b[$];

  // model state per DUT: index 0 = A, 1 = B
  bit m_hist [2][0:4];
  bit m_pend [2];
  bit m_ack  [2];
  bit m_ovr  [2];
  int m_cnt  [2];

  always #5 clk_slow = ~clk_slow;

  handshake_sync_rx_if #(.CNT_W(W_A)) if_a ();
  handshake_sync_rx_if #(.CNT_W(W_B)) if_b ();

  assign if_a.req_toggle  = req_toggle;
  assign if_a.ready_in    = ready_in;
  assign if_a.clr_overrun = clr_overrun;
  assign if_b.req_toggle  = req_toggle;
  assign if_b.ready_in    = ready_in;
  assign if_b.clr_overrun = clr_overrun;

  handshake_sync_rx #(.SYNC_STAGES(S_A), .CNT_W(W_A)) dut_a (
    .clk_slow (clk_slow),
    .rst_n    (rst_n),
    .bus      (if_a.slave)
  );

  handshake_sync_rx #(.SYNC_STAGES(S_B), .CNT_W(W_B)) dut_b (
    .clk_slow (clk_slow),
    .rst_n    (rst_n),
    .bus      (if_b.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: a request becomes visible S edges after it is sampled;
  // then the pending/accept/drop rules are applied at request level.
  always @(posedge clk_slow) begin
    exp_t e;
    bit   ev;
    bit   pulse;
    bit   ovr_set;
    int   s;
    int   w;
    for (int d = 0; d < 2; d++) begin
      s = (d == 0) ? S_A : S_B;
      w = (d == 0) ? W_A : W_B;
      if (!rst_n) begin
        for (int k = 0; k < 5; k++) m_hist[d][k] = 1'b0;
        m_pend[d] = 1'b0;
        m_ack[d]  = 1'b0;
        m_ovr[d]  = 1'b0;
        m_cnt[d]  = 0;
        pulse     = 1'b0;
      end else begin
        ev = m_hist[d][s-1] ^ m_hist[d][s];
        for (int k = 4; k >= 1; k--) m_hist[d][k] = m_hist[d][k-1];
        m_hist[d][0] = req_toggle;
        pulse   = 1'b0;
        ovr_set = 1'b0;
        if (!m_pend[d]) begin
          if (ev) begin
            m_pend[d] = 1'b1;
            pulse     = 1'b1;
          end
        end else if (ready_in) begin
          m_cnt[d] = (m_cnt[d] + 1) % (1 << w);
          m_ack[d] = ~m_ack[d];
          if (ev) pulse = 1'b1;
          else    m_pend[d] = 1'b0;
        end else if (ev) begin
          ovr_set = 1'b1;
        end
        if (ovr_set)          m_ovr[d] = 1'b1;
        else if (clr_overrun) m_ovr[d] = 1'b0;
      end
      e = '{pulse: pulse, busy: m_pend[d], ack: m_ack[d], ovr: m_ovr[d], cnt: m_cnt[d]};
      if (d == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
  end

  // Monitor: compares whatever the DUTs present against the queued prediction.
  always @(negedge clk_slow) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("A.pulse_out",  32'(if_a.pulse_out),  32'(e.pulse));
      chk("A.busy",       32'(if_a.busy),       32'(e.busy));
      chk("A.ack_toggle", 32'(if_a.ack_toggle), 32'(e.ack));
      chk("A.event_cnt",  32'(if_a.event_cnt),  32'(e.cnt));
      chk("A.overrun",    32'(if_a.overrun),    32'(e.ovr));
      if (verbose && if_a.pulse_out)
        $display("[TB] A request: cnt=%0d ack=%0b ovr=%0b", if_a.event_cnt, if_a.ack_toggle, if_a.overrun);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      chk("B.pulse_out",  32'(if_b.pulse_out),  32'(e.pulse));
      chk("B.busy",       32'(if_b.busy),       32'(e.busy));
      chk("B.ack_toggle", 32'(if_b.ack_toggle), 32'(e.ack));
      chk("B.event_cnt",  32'(if_b.event_cnt),  32'(e.cnt));
      chk("B.overrun",    32'(if_b.overrun),    32'(e.ovr));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_slow);
  endtask

  // Asserts reset mid-cycle and checks outputs clear without a clock edge.
  task automatic do_reset(input bit clear_req);
    @(negedge clk_slow);
    #2;
    rst_n       = 1'b0;
    ready_in    = 1'b0;
    clr_overrun = 1'b0;
    if (clear_req) req_toggle = 1'b0;
    #1;
    chk("rst.A.outputs", {if_a.pulse_out, if_a.busy, if_a.ack_toggle, if_a.overrun, 24'(if_a.event_cnt)}, 32'd0);
    chk("rst.B.outputs", {if_b.pulse_out, if_b.busy, if_b.ack_toggle, if_b.overrun, 25'(if_b.event_cnt)}, 32'd0);
    @(negedge clk_slow);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    req_toggle  = 1'b0;
    ready_in    = 1'b0;
    clr_overrun = 1'b0;
    cyc(3);
    #2;
    rst_n = 1'b1;

    // single request, accepted two cycles after the strobe
    cyc(1);
    req_toggle = ~req_toggle;
    cyc(3);
    chk("single.A.pulse_edge3", 32'(if_a.pulse_out), 32'd1);
    cyc(1);
    ready_in = 1'b1;
    cyc(1);
    ready_in = 1'b0;
    cyc(2);
    chk("single.A.cnt", 32'(if_a.event_cnt), 32'd1);
    chk("single.A.ack", 32'(if_a.ack_toggle), 32'd1);
    $display("[TB] single request done");

    // back-to-back: new request lands on the cycle the previous is accepted
    do_reset(1'b1);
    cyc(1);
    req_toggle = ~req_toggle;
    cyc(5);
    req_toggle = ~req_toggle;
    cyc(2);
    ready_in = 1'b1;
    cyc(1);
    ready_in = 1'b0;
    cyc(3);
    ready_in = 1'b1;
    cyc(1);
    ready_in = 1'b0;
    cyc(3);
    chk("b2b.A.cnt", 32'(if_a.event_cnt), 32'd2);
    chk("b2b.A.ack", 32'(if_a.ack_toggle), 32'd0);
    chk("b2b.A.ovr", 32'(if_a.overrun), 32'd0);
    $display("[TB] back-to-back done");

    // overrun, then clear coinciding with a third dropped request
    do_reset(1'b1);
    cyc(1);
    req_toggle = ~req_toggle;
    cyc(4);
    req_toggle = ~req_toggle;
    cyc(6);
    chk("ovr.A.ovr", 32'(if_a.overrun), 32'd1);
    chk("ovr.A.cnt", 32'(if_a.event_cnt), 32'd0);
    req_toggle = ~req_toggle;
    cyc(2);
    clr_overrun = 1'b1;
    cyc(1);
    clr_overrun = 1'b0;
    cyc(1);
    chk("ovr.A.set_wins", 32'(if_a.overrun), 32'd1);
    clr_overrun = 1'b1;
    cyc(1);
    clr_overrun = 1'b0;
    chk("ovr.A.cleared", 32'(if_a.overrun), 32'd0);
    ready_in = 1'b1;
    cyc(1);
    ready_in = 1'b0;
    cyc(2);
    $display("[TB] overrun done");

    // nine complete pairs: 3-bit counter wraps to 1
    do_reset(1'b1);
    cyc(1);
    for (int i = 0; i < 9; i++) begin
      req_toggle = ~req_toggle;
      cyc(8);
      ready_in = 1'b1;
      cyc(1);
      ready_in = 1'b0;
      cyc(2);
    end
    chk("wrap.B.cnt", 32'(if_b.event_cnt), 32'd1);
    chk("wrap.B.ack", 32'(if_b.ack_toggle), 32'd1);
    chk("wrap.A.cnt", 32'(if_a.event_cnt), 32'd9);
    $display("[TB] wrap done");

    // reset while pending, then a normal request
    req_toggle = ~req_toggle;
    cyc(4);
    chk("midrst.A.busy_before", 32'(if_a.busy), 32'd1);
    do_reset(1'b0);
    cyc(1);
    req_toggle = ~req_toggle;
    cyc(4);
    ready_in = 1'b1;
    cyc(1);
    ready_in = 1'b0;
    cyc(2);
    chk("midrst.A.cnt", 32'(if_a.event_cnt), 32'd1);
    chk("midrst.A.ack", 32'(if_a.ack_toggle), 32'd1);
    $display("[TB] reset mid-request done");

    // randomized traffic, occasional resets
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_slow);
      if ($urandom_range(0, 5) == 0) req_toggle = ~req_toggle;
      ready_in    = ($urandom_range(0, 1) == 1);
      clr_overrun = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 599) == 0) do_reset(1'($urandom_range(0, 1)));
    end
    ready_in    = 1'b0;
    clr_overrun = 1'b0;
    cyc(3);
    chk("queue.A.drained", 32'(q_a.size() <= 1), 32'd1);
    chk("queue.B.drained", 32'(q_b.size() <= 1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
